// File: rtl/seg_pkg.sv
// Shared constants and FSM encoding for the scrolling 7-segment controller.
package seg_pkg;

    localparam int unsigned SEG_BLANK = 0;

    localparam logic [3:0] DIG0    = 4'b1110;
    localparam logic [3:0] DIG1    = 4'b1101;
    localparam logic [3:0] DIG2    = 4'b1011;
    localparam logic [3:0] DIG3    = 4'b0111;
    localparam logic [3:0] DIG_OFF = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StWait,
        StDrain,
        StFin
    } state_e;

endpackage

// File: rtl/seg_scan_mux.sv
// Free-running digit scan: divider, digit index and registered seg/digit_n mux.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV_W = 16,
    parameter int unsigned SEG_W     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*SEG_W-1:0] i_win,
    output logic               o_scan_tick,
    output logic [SEG_W-1:0]   o_seg,
    output logic [3:0]         o_digit_n
);

    logic [CLK_DIV_W-1:0] r_div;
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_nxt;
    logic                 w_tick;
    logic [SEG_W-1:0]     r_seg;
    logic [SEG_W-1:0]     w_seg_nxt;
    logic [3:0]           r_digit_n;
    logic [3:0]           w_digit_nxt;

    // Tick is the last count before the divider wraps back to zero.
    assign w_tick    = &r_div;
    assign w_idx_nxt = r_idx + {1'b0, w_tick};

    always_comb begin
        w_seg_nxt   = i_win[SEG_W-1:0];
        w_digit_nxt = DIG0;
        unique case (w_idx_nxt)
            2'd0: begin
                w_seg_nxt   = i_win[0*SEG_W +: SEG_W];
                w_digit_nxt = DIG0;
            end
            2'd1: begin
                w_seg_nxt   = i_win[1*SEG_W +: SEG_W];
                w_digit_nxt = DIG1;
            end
            2'd2: begin
                w_seg_nxt   = i_win[2*SEG_W +: SEG_W];
                w_digit_nxt = DIG2;
            end
            2'd3: begin
                w_seg_nxt   = i_win[3*SEG_W +: SEG_W];
                w_digit_nxt = DIG3;
            end
            default: begin
                w_seg_nxt   = i_win[SEG_W-1:0];
                w_digit_nxt = DIG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_idx     <= 2'd0;
            r_seg     <= '0;
            r_digit_n <= DIG_OFF;
        end else begin
            r_div     <= r_div + 1'b1;
            r_idx     <= w_idx_nxt;
            r_seg     <= w_seg_nxt;
            r_digit_n <= w_digit_nxt;
        end
    end

    assign o_scan_tick = w_tick;
    assign o_seg       = r_seg;
    assign o_digit_n   = r_digit_n;

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolling-text sequencer: fetches characters over req/ack, shifts a 4-digit window
// at a programmable rate and drives the multiplexed display through seg_scan_mux.
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV_W    = 16,
    parameter int unsigned SCROLL_TICKS = 64,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned SEG_W        = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] msg_len,
    input  logic              loop_en,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [SEG_W-1:0]  rd_data,
    output logic [SEG_W-1:0]  seg,
    output logic [3:0]        digit_n,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       TCNT_W      = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(SCROLL_TICKS - 1);
    localparam logic [2:0]        DRAIN_STEPS = 3'd4;

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_req;
    logic                 w_req_nxt;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic [ADDR_W-1:0]    r_len;
    logic [ADDR_W-1:0]    w_len_nxt;
    logic [4*SEG_W-1:0]   r_win;
    logic [4*SEG_W-1:0]   w_win_nxt;
    logic [SEG_W-1:0]     r_char;
    logic [SEG_W-1:0]     w_char_nxt;
    logic [SEG_W-1:0]     w_shift_in;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [TCNT_W-1:0]    r_tick_cnt;
    logic [TCNT_W-1:0]    w_tick_cnt_nxt;
    logic [2:0]           r_drain_cnt;
    logic [2:0]           w_drain_cnt_nxt;
    logic                 r_draining;
    logic                 w_draining_nxt;
    logic                 r_loop;
    logic                 w_loop_nxt;
    logic                 w_scan_tick;

    seg_scan_mux #(
        .CLK_DIV_W (CLK_DIV_W),
        .SEG_W     (SEG_W)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_win       (r_win),
        .o_scan_tick (w_scan_tick),
        .o_seg       (seg),
        .o_digit_n   (digit_n)
    );

    assign w_shift_in = r_draining ? SEG_W'(SEG_BLANK) : r_char;

    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_addr_nxt      = r_addr;
        w_len_nxt       = r_len;
        w_win_nxt       = r_win;
        w_char_nxt      = r_char;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_draining_nxt  = r_draining;
        w_loop_nxt      = r_loop;

        // Abort overrides everything, including an ack arriving in the same cycle.
        if (stop && (r_state != StIdle)) begin
            w_state_nxt    = StIdle;
            w_req_nxt      = 1'b0;
            w_win_nxt      = '0;
            w_busy_nxt     = 1'b0;
            w_draining_nxt = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start && !stop) begin
                        if (msg_len != '0) begin
                            w_len_nxt       = msg_len;
                            w_addr_nxt      = '0;
                            w_busy_nxt      = 1'b1;
                            w_drain_cnt_nxt = 3'd0;
                            w_draining_nxt  = 1'b0;
                            w_state_nxt     = StFetch;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (r_req && rd_ack) begin
                        w_char_nxt  = rd_data;
                        w_req_nxt   = 1'b0;
                        w_state_nxt = StShift;
                    end else begin
                        w_req_nxt = 1'b1;
                    end
                end
                StShift: begin
                    w_win_nxt = {r_win[3*SEG_W-1:0], w_shift_in};
                    if (r_draining) begin
                        w_drain_cnt_nxt = r_drain_cnt + 3'd1;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                    w_tick_cnt_nxt = '0;
                    w_state_nxt    = StWait;
                end
                StWait: begin
                    if (w_scan_tick) begin
                        if (r_tick_cnt == TCNT_LAST) begin
                            if (!r_draining && (r_addr < r_len)) begin
                                w_state_nxt = StFetch;
                            end else begin
                                w_state_nxt = StDrain;
                            end
                        end else begin
                            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (r_drain_cnt == DRAIN_STEPS) begin
                        w_loop_nxt  = loop_en;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StFin;
                    end else begin
                        w_draining_nxt = 1'b1;
                        w_state_nxt    = StShift;
                    end
                end
                StFin: begin
                    w_draining_nxt  = 1'b0;
                    w_drain_cnt_nxt = 3'd0;
                    if (r_loop) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = StFetch;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_win       <= '0;
            r_char      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tick_cnt  <= '0;
            r_drain_cnt <= 3'd0;
            r_draining  <= 1'b0;
            r_loop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_len       <= w_len_nxt;
            r_win       <= w_win_nxt;
            r_char      <= w_char_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_draining  <= w_draining_nxt;
            r_loop      <= w_loop_nxt;
        end
    end

    assign rd_req  = r_req;
    assign rd_addr = r_addr;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl: table-driven passes, random passes against a
// window/scan reference model, and hand-written stop, loop and async-reset sequences.
module tb_seg_scroll_ctrl;
    import seg_pkg::*;

    localparam int unsigned CDW   = 4;
    localparam int unsigned STK   = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned SW    = 7;
    localparam int          LIMIT = 3000;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          loop_en = 1'b0;
    logic          rd_ack  = 1'b0;
    logic [AW-1:0] msg_len = '0;
    logic [SW-1:0] rd_data = '0;
    logic          rd_req;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] seg;
    logic [3:0]    digit_n;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scroll_ctrl #(
        .CLK_DIV_W    (CDW),
        .SCROLL_TICKS (STK),
        .ADDR_W       (AW),
        .SEG_W        (SW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .msg_len (msg_len),
        .loop_en (loop_en),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .seg     (seg),
        .digit_n (digit_n),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; drives the expected scan position.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Message memory and reference model state.
    logic [SW-1:0] mem [32];
    logic [SW-1:0] m_win [4];
    int            m_addr_q[$];
    int            g_delay   = 0;
    bit            g_resp_en = 1'b1;
    int            m_len, m_k, m_shift_cnt, m_done_cnt;
    bit            m_busy_seen, m_req_seen, m_pend;
    bit            m_prev_req;
    logic [AW-1:0] m_prev_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*SW-1:0] model_win();
        return {m_win[3], m_win[2], m_win[1], m_win[0]};
    endfunction

    // Memory responder: acks a held request after g_delay cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (g_resp_en) begin
                rd_ack = 1'b0;
                if (rd_req && rst_n) begin
                    if (cnt >= g_delay) begin
                        rd_ack  = 1'b1;
                        rd_data = mem[rd_addr];
                        m_addr_q.push_back(int'(rd_addr));
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: window model (shift left, new char at digit 0), done/busy/req bookkeeping.
    initial begin
        logic [SW-1:0] c;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pend = 1'b0;
                for (int i = 0; i < 4; i++) m_win[i] = '0;
            end else begin
                if (m_pend) begin
                    check("win_after_shift", dut.r_win, model_win());
                    m_pend = 1'b0;
                end
                if (dut.r_state == StShift) begin
                    c = (m_k < m_len) ? mem[m_k] : '0;
                    m_win[3] = m_win[2];
                    m_win[2] = m_win[1];
                    m_win[1] = m_win[0];
                    m_win[0] = c;
                    m_k++;
                    m_shift_cnt++;
                    m_pend = 1'b1;
                end
                if (done) begin
                    m_done_cnt++;
                    m_k = 0;
                end
                if (busy)   m_busy_seen = 1'b1;
                if (rd_req) m_req_seen  = 1'b1;
                if (rd_req && m_prev_req) check("addr_stable", rd_addr, m_prev_addr);
                m_prev_req  = rd_req;
                m_prev_addr = rd_addr;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_pass(input int len);
        m_len       = len;
        m_k         = 0;
        m_shift_cnt = 0;
        m_done_cnt  = 0;
        m_busy_seen = 1'b0;
        m_req_seen  = 1'b0;
        m_addr_q.delete();
        msg_len = AW'(len);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_pass(input string nm, input int len, input int exp_shifts,
                               input bit exp_seen);
        int c;
        c = 0;
        while (!(m_done_cnt > 0 && busy == 1'b0) && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_timeout"}, 64'(c < LIMIT), 64'd1);
        tick(3);
        check({nm, "_shifts"}, m_shift_cnt, exp_shifts);
        check({nm, "_done_cycles"}, m_done_cnt, 1);
        check({nm, "_busy_end"}, busy, 1'b0);
        check({nm, "_req_end"}, rd_req, 1'b0);
        check({nm, "_win_end"}, dut.r_win, '0);
        check({nm, "_busy_seen"}, m_busy_seen, exp_seen);
        check({nm, "_req_seen"}, m_req_seen, exp_seen);
        check({nm, "_n_reads"}, m_addr_q.size(), len);
        for (int i = 0; i < m_addr_q.size(); i++) check({nm, "_rd_addr"}, m_addr_q[i], i);
    endtask

    task automatic wait_shifts(input int n);
        int c;
        c = 0;
        while (m_shift_cnt < n && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        check("wait_shifts", 64'(c < LIMIT), 64'd1);
    endtask

    task automatic wait_req();
        int c;
        c = 0;
        while (!rd_req && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        check("wait_req", 64'(c < LIMIT), 64'd1);
    endtask

    typedef struct {
        int          len;
        int          delay;
        logic [27:0] dat;
        int          exp_shifts;
        bit          exp_seen;
    } vec_t;

    vec_t          vecs[4];
    logic [3:0]    exp_dig;
    logic [4*SW-1:0] exp_pack;
    int            idx, len, a0;

    initial begin
        vecs[0] = '{3, 1, {7'h00, 7'h39, 7'h7C, 7'h77}, 7, 1'b1};
        vecs[1] = '{1, 0, {7'h00, 7'h00, 7'h00, 7'h06}, 5, 1'b1};
        vecs[2] = '{4, 3, {7'h66, 7'h4F, 7'h5B, 7'h3F}, 8, 1'b1};
        vecs[3] = '{0, 0, 28'h0,                       0, 1'b0};
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) m_win[i] = '0;

        // Reset values.
        tick(3);
        check("rst_seg", seg, '0);
        check("rst_digit_n", digit_n, 4'b1111);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_rd_addr", rd_addr, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Table-driven passes.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) mem[i] = vecs[v].dat[i*7 +: 7];
            g_delay = vecs[v].delay;
            begin_pass(vecs[v].len);
            finish_pass("vec", vecs[v].len, vecs[v].exp_shifts, vecs[v].exp_seen);
        end

        // Preload window {39,7C,77,00}, stall the 5th fetch and check scan + held request.
        mem[0] = 7'h39; mem[1] = 7'h7C; mem[2] = 7'h77; mem[3] = 7'h00; mem[4] = 7'h5B;
        g_delay = 0;
        begin_pass(5);
        wait_shifts(4);
        g_resp_en = 1'b0;
        rd_ack    = 1'b0;
        wait_req();
        tick(2);
        exp_pack = {7'h39, 7'h7C, 7'h77, 7'h00};
        check("stall_win", dut.r_win, exp_pack);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            idx     = (cyc / 16) % 4;
            exp_dig = 4'b1111 ^ (4'b0001 << idx);
            check("scan_digit_n", digit_n, exp_dig);
            check("scan_seg", seg, m_win[idx]);
            check("stall_req", rd_req, 1'b1);
        end
        check("stall_addr", rd_addr, 5'd4);
        check("stall_win_hold", dut.r_win, exp_pack);
        g_resp_en = 1'b1;
        finish_pass("stall", 5, 9, 1'b1);

        // Randomised passes.
        for (int r = 0; r < 6; r++) begin
            len     = $urandom_range(1, 8);
            g_delay = $urandom_range(0, 4);
            for (int i = 0; i < len; i++) mem[i] = SW'($urandom_range(1, 127));
            begin_pass(len);
            finish_pass("rand", len, len + 4, 1'b1);
        end

        // start while busy has no effect.
        mem[0] = 7'h11; mem[1] = 7'h22; mem[2] = 7'h33;
        g_delay = 1;
        begin_pass(3);
        wait_shifts(1);
        msg_len = 5'd7;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_addr", rd_addr, 5'd1);
        tick(2);
        check("busy_start_addr2", rd_addr, 5'd1);
        finish_pass("busy_start", 3, 7, 1'b1);

        // stop during FETCH coincident with ack.
        mem[0] = 7'h4F; mem[1] = 7'h66; mem[2] = 7'h6D;
        g_delay = 0;
        begin_pass(3);
        wait_shifts(1);
        g_resp_en = 1'b0;
        rd_ack    = 1'b0;
        wait_req();
        rd_ack  = 1'b1;
        rd_data = 7'h55;
        stop    = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        stop   = 1'b0;
        check("stop_req", rd_req, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_win", dut.r_win, '0);
        for (int i = 0; i < 4; i++) m_win[i] = '0;
        tick(2);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        tick(40);
        check("stop_no_done", m_done_cnt, 0);
        check("stop_late_ack_busy", busy, 1'b0);
        check("stop_late_ack_req", rd_req, 1'b0);
        check("stop_shifts", m_shift_cnt, 1);
        g_resp_en = 1'b1;

        // loop_en restarts the pass; then async reset mid-WAIT.
        mem[0] = 7'h5E; mem[1] = 7'h71;
        g_delay = 0;
        loop_en = 1'b1;
        begin_pass(2);
        a0 = 0;
        while (!done && a0 < LIMIT) begin
            @(negedge clk);
            a0++;
        end
        check("loop_done_timeout", 64'(a0 < LIMIT), 64'd1);
        check("loop_shifts_at_done", m_shift_cnt, 6);
        @(negedge clk);
        check("loop_busy", busy, 1'b1);
        check("loop_addr", rd_addr, '0);
        check("loop_done_1cyc", done, 1'b0);
        @(negedge clk);
        check("loop_req", rd_req, 1'b1);
        wait_shifts(7);
        tick(3);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", seg, '0);
        check("arst_digit_n", digit_n, 4'b1111);
        check("arst_rd_req", rd_req, 1'b0);
        check("arst_rd_addr", rd_addr, '0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_win", dut.r_win, '0);
        @(negedge clk);
        loop_en = 1'b0;
        rst_n   = 1'b1;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/seg_scroll_ctrl.md
Name: seg_scroll_ctrl

Overview:
- Sequences a 4-digit multiplexed 7-segment display for scrolling text.
- Fetches character codes from an external message memory over a req/ack read handshake.
- Keeps a 4-character window, shifts it left at a programmable rate, and drives the digit scan.
- Sits between the message store and the display pins: seg, active-low digit enables.

Parameters:
- CLK_DIV_W, 16: scan tick every 2^CLK_DIV_W clocks.
- SCROLL_TICKS, 64: scan ticks per scroll step (≥1).
- ADDR_W, 5: message address width; a message is at most 2^ADDR_W-1 characters.
- SEG_W, 7: segment code width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled in IDLE only.
- stop  in  1  abort at any time.
- msg_len  in  ADDR_W  number of characters; sampled when start is accepted.
- loop_en  in  1  restart after each pass; sampled at end of drain.
- rd_req  out  1  read request; held until ack.
- rd_addr  out  ADDR_W  character address; stable while rd_req=1.
- rd_ack  in  1  read data valid this cycle.
- rd_data  in  SEG_W  segment code.
- seg  out  SEG_W  segment drive for the selected digit.
- digit_n  out  4  active-low digit select; 1110 = rightmost.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse at the end of each pass.

Behaviour:
- Reset (async, immediate): seg=0, digit_n=1111, rd_req=0, rd_addr=0, busy=0, done=0, window=all blank (0), FSM=IDLE, all counters 0.
- Scan:
  - Free-running CLK_DIV_W-bit counter; scan tick when it wraps to 0.
  - Each tick, a 2-bit digit index increments mod 4.
  - Registered outputs: index 0→digit_n 1110, seg=win[0]; 1→1101, win[1]; 2→1011, win[2]; 3→0111, win[3].
  - Outputs update the cycle after the tick.
  - Scan runs in all states, including IDLE.
- FSM states: IDLE, FETCH, SHIFT, WAIT, DRAIN, FIN.
- IDLE:
  - start=1 and msg_len≠0 → latch msg_len, rd_addr=0, busy=1 → FETCH.
  - start=1 and msg_len=0 → done=1 next cycle, stay IDLE, busy stays 0.
- FETCH:
  - rd_req=1 from the cycle after entry until rd_ack is seen with rd_req=1.
  - Capture rd_data on that cycle; rd_req=0 the next cycle → SHIFT.
  - No timeout.
  - rd_ack while rd_req=0 is ignored.
- SHIFT (1 cycle):
  - win[3]←win[2], win[2]←win[1], win[1]←win[0], win[0]←char; increment rd_addr.
  - Normal pass: char = captured data.
  - During drain: char = blank (0).
  - Then → WAIT.
- WAIT:
  - Count SCROLL_TICKS scan ticks, counter cleared on entry.
  - On reaching the count: if characters remain → FETCH; else → DRAIN.
- DRAIN: performs 4 blank SHIFT+WAIT steps so the text scrolls fully off, then → FIN.
- FIN:
  - done=1 for one cycle.
  - loop_en=1 → rd_addr=0 → FETCH, busy stays 1.
  - Else → IDLE, busy=0.
- A pass of N characters produces exactly N+4 shifts.
- stop=1 in any non-IDLE state, next cycle:
  - rd_req=0, window cleared to blank, busy=0, FSM=IDLE, no done.
  - A late rd_ack is ignored.
- Priority and overlap rules:
  - stop and start in the same cycle: stop wins, start is ignored.
  - start while busy: ignored.
  - stop and rd_ack in the same cycle: data dropped.
- Widths: rd_addr is compared against the latched msg_len; it never wraps within a pass.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=0.
  - Digit select constants DIG0..DIG3 (1110, 1101, 1011, 0111) and DIG_OFF=1111.
  - FSM state enum.
- One sub-module, seg_scan_mux:
  - Contents: scan divider, digit index, registered seg/digit_n mux.
  - Inputs: the 4-entry window.
  - Outputs: a scan_tick strobe to the sequencer.

Test Plan:
All scenarios use CLK_DIV_W=4, SCROLL_TICKS=2.
1. Scan with window preloaded {39,7C,77,00} → digit_n cycles 1110→1101→1011→0111, 16 clocks each; seg equals win[index].
2. msg_len=3, data 77,7C,39, ack 1 cycle after req → rd_addr sequence 0,1,2; window after 3rd shift = {win3..0}={00,77,7C,39}; 4 blank shifts follow; done pulses once; busy=0 after; 7 shifts total.
3. Slow ack: hold rd_ack=0 for 10 cycles → rd_req stays 1, rd_addr stable, window unchanged; ack → single capture.
4. stop during FETCH coincident with rd_ack → data dropped, window all 0, busy=0, done never asserted, rd_req=0 next cycle.
5. start with msg_len=0 → done high exactly 1 cycle, busy and rd_req never asserted. Separately, start pulsed while busy → no effect on rd_addr.
6. loop_en=1, msg_len=2 → done pulse after 6 shifts, then rd_addr=0, rd_req=1, busy stays 1. Then rst_n low mid-WAIT → all outputs at reset values asynchronously, digit_n=1111.
